// File: rtl/lu_serial_driver_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial logic-unit driver.
// Opcode bit 0 selects inversion, bit 1 selects the AND group over the OR group.
package lu_serial_driver_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Counter must be able to represent 0..WIDTH without overflow.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lu_bit_counter.sv
// Loadable bit counter for the serial driver; flags the last bit position (WIDTH-1).
// Counting stops at the terminal value, so the counter never wraps.
module lu_bit_counter
  import lu_serial_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en && !last) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign last = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/lu_serial_driver.sv
// Bit-serial sequencer feeding an external 1-bit logic unit and reassembling its result word.
// Optional zero flag output is enabled by defining LU_SERIAL_ZERO_FLAG_EN.
module lu_serial_driver
  import lu_serial_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_select_op,
  output logic             lu_select_grp,
  input  logic             lu_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef LU_SERIAL_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg, result_next;
  logic             sel_op_reg, sel_grp_reg;
  logic             load, shift_en, cnt_last;

  assign load     = (state_reg == S_IDLE) && in_valid;
  assign shift_en = (state_reg == S_SHIFT);

  lu_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .en    (shift_en),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid)  state_next = S_SHIFT;
      S_SHIFT: if (cnt_last)  state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // in_ready is gated by reset so it reads 0 while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    lu_a      = 1'b0;
    lu_b      = 1'b0;
    case (state_reg)
      S_IDLE:  in_ready = !reset;
      S_SHIFT: begin
        lu_a = a_reg[0];
        lu_b = b_reg[0];
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // LU result enters at the MSB so bit 0 lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_result_w1
      assign result_next = lu_s;
    end else begin : g_result_wn
      assign result_next = {lu_s, result_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      sel_op_reg  <= 1'b0;
      sel_grp_reg <= 1'b0;
    end else if (load) begin
      a_reg       <= in_a;
      b_reg       <= in_b;
      sel_op_reg  <= in_op[0];
      sel_grp_reg <= in_op[1];
    end else if (shift_en) begin
      a_reg      <= a_reg >> 1;
      b_reg      <= b_reg >> 1;
      result_reg <= result_next;
    end
  end

  assign lu_select_op  = sel_op_reg;
  assign lu_select_grp = sel_grp_reg;
  assign out_result    = result_reg;

`ifdef LU_SERIAL_ZERO_FLAG_EN
  logic zero_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_reg <= 1'b0;
    end else if (shift_en && cnt_last) begin
      zero_reg <= (result_next == '0);
    end
  end

  assign out_zero = zero_reg;
`endif

endmodule
